led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
- Drives the 8x8 LED matrix for the Tetris display by time-multiplexing one row at a time.
- Sits downstream of the game/board logic: that logic hands over a 64-bit frame through a valid/ready handshake, and this block double-buffers it.
- Built around a row-slot prescaler and a 3-bit row counter, with a blanking interval at the start of every row slot to suppress ghosting.

Parameters:
PRESCALE, 1024, clock cycles per row slot (must be >= 2)
BLANK, 16, cycles at the start of each row slot during which all outputs are dark (must satisfy 0 <= BLANK < PRESCALE)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset); asserts immediately, deassertion sampled on clk
frame_in  input  64  new frame; pixel (row r, col c) = frame_in[8*r + c], 1 = lit
frame_valid  input  1  frame_in holds a frame to transfer
frame_ready  output  1  pending buffer empty; transfer occurs on a cycle with frame_valid && frame_ready
row_out  output  8  one-hot row enable, active-high, bit r = row r
col_out  output  8  column data for the enabled row, active-high, bit c = column c
frame_done  output  1  one-cycle pulse on the last cycle of row 7 (frame boundary)

Behaviour:
- State: presc (width $clog2(PRESCALE), counts 0..PRESCALE-1), row (3 bits), display[63:0], pending[63:0], pending_full, and registered row_out/col_out/frame_done.
- Reset while asserted: presc=0, row=0, display=0, pending=0, pending_full=0, row_out=0, col_out=0, frame_done=0. frame_ready = ~pending_full, so it reads 1 during and after reset. An assertion mid-scan clears everything on the spot; the scan restarts at row 0, presc 0, with a blank display.
- Prescaler: presc increments every cycle. At PRESCALE-1 it wraps to 0 and row increments; row 7 wraps to 0.
- Frame boundary: the cycle with row==7 && presc==PRESCALE-1. frame_done is 1 on exactly that cycle, so its period is 8*PRESCALE cycles.
- Output decode: outputs are registers loaded from the next-cycle (presc,row,display) values, so row_out/col_out/frame_done are always consistent with presc/row on the same cycle (zero extra latency).
  - BLANK phase (presc < BLANK): row_out=0, col_out=0.
  - DRIVE phase (presc >= BLANK): row_out = 1<<row, col_out = display[8*row +: 8].
  - If BLANK=0, there is no dark interval.
- row_out scans even when display is all zero.
- Handshake capture: on frame_valid && frame_ready, pending <= frame_in and pending_full <= 1. frame_in may change freely afterwards. frame_valid while frame_ready=0 is ignored; the source must hold it.
- Swap: on a frame-boundary cycle with pending_full==1 (registered value), display <= pending and pending_full <= 0. The new frame appears from row 0 of the next frame; a frame is never torn mid-scan.
- Simultaneous events at a boundary:
  - If pending_full==0 and a capture occurs on the boundary cycle, the frame goes into pending only. It is displayed at the following boundary.
  - If pending_full==1, frame_ready=0 on the boundary cycle, so no capture; frame_ready rises the cycle after the swap.
- Throughput: at most one frame per 8*PRESCALE cycles reaches display. Extra frames back-pressure the source; they are never dropped or overwritten.

Test Plan:
Use PRESCALE=8, BLANK=2 (frame = 64 cycles).
- Reset: hold reset=0 for 3 cycles, then release. -> row_out=0, col_out=0, frame_done=0, frame_ready=1 during reset. After release, row_out=00000001 from presc 2 to 7, then 00000010, and so on; col_out stays 0.
- Load diagonal frame 64'h8040201008040201 one cycle after reset release. -> frame_ready drops to 0 for the next cycle. frame_done pulses at cycle 63. From cycle 64 onward, for each row r, presc 0-1 gives row_out=0, col_out=0 and presc 2-7 gives row_out=1<<r, col_out=1<<r. frame_ready=1 again at cycle 64.
- Back-pressure: send frame A=all-ones and, immediately after, hold frame_valid with B=64'h00000000000000FF. -> B is held off, with frame_ready=0 until the cycle after the boundary that swaps in A. B is then captured; A shows all rows col_out=FF during that frame, and B shows row 0 only (col_out=FF on row 0, 00 elsewhere) in the frame after.
- Boundary capture: with pending empty, raise frame_valid exactly on a frame_done cycle. -> Frame captured (frame_ready=0 next cycle) but display unchanged for the following 64 cycles, then shown.
- Periodicity: run 5 frames. -> frame_done asserted exactly once per 64 cycles, each pulse 1 cycle wide. row_out is never multi-hot and is 0 for exactly 16 cycles per frame.
- Reset mid-scan: drop reset at row 4, presc 5, with a frame pending. -> row_out/col_out go to 0 without waiting for a clock edge; frame_ready=1. After release, the scan restarts at row 0 with a blank display and the pending frame discarded.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: time-multiplexed 8x8 LED matrix driver with a
// double-buffered frame input.
//   clk         - system clock, all state on the rising edge
//   reset       - asynchronous, active-low reset
//   frame_in    - 64-bit frame, pixel (r,c) = frame_in[8*r + c]
//   frame_valid - frame_in holds a frame to transfer
//   frame_ready - pending buffer empty (transfer on valid && ready)
//   row_out     - one-hot row enable, dark during the blanking interval
//   col_out     - column data for the enabled row
//   frame_done  - one-cycle pulse on the last cycle of row 7
module led_matrix_scanner #(
    parameter int unsigned PRESCALE = 1024,
    parameter int unsigned BLANK    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic [7:0]  row_out,
    output logic [7:0]  col_out,
    output logic        frame_done
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_n;
    logic [2:0]    row;
    logic [2:0]    row_n;
    logic [63:0]   display;
    logic [63:0]   display_n;
    logic [63:0]   pending;
    logic          pending_full;
    logic          wrap;
    logic          boundary;
    logic          swap;
    logic          capture;
    logic          blank_n;
    logic [7:0]    row_out_n;
    logic [7:0]    col_out_n;
    logic          frame_done_n;

    // Next-cycle scan position, buffer swap and output decode. Outputs are
    // registered from the next-cycle values so they line up with presc/row.
    always_comb begin
        wrap         = 1'b0;
        boundary     = 1'b0;
        swap         = 1'b0;
        capture      = 1'b0;
        presc_n      = presc;
        row_n        = row;
        display_n    = display;
        blank_n      = 1'b1;
        row_out_n    = 8'h00;
        col_out_n    = 8'h00;
        frame_done_n = 1'b0;

        wrap     = (presc == PRESC_MAX);
        boundary = wrap && (row == 3'd7);
        // Swap and capture are mutually exclusive: both key off pending_full.
        swap     = boundary && pending_full;
        capture  = frame_valid && !pending_full;

        presc_n   = wrap ? '0 : presc + PW'(1);
        row_n     = wrap ? row + 3'd1 : row;
        display_n = swap ? pending : display;

        blank_n = (presc_n < BLANK_END);
        if (!blank_n) begin
            row_out_n = 8'(1) << row_n;
            col_out_n = display_n[{row_n, 3'b000} +: 8];
        end
        frame_done_n = (row_n == 3'd7) && (presc_n == PRESC_MAX);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc        <= '0;
            row          <= 3'd0;
            display      <= 64'd0;
            pending      <= 64'd0;
            pending_full <= 1'b0;
            row_out      <= 8'h00;
            col_out      <= 8'h00;
            frame_done   <= 1'b0;
        end else begin
            presc   <= presc_n;
            row     <= row_n;
            display <= display_n;
            if (swap) begin
                pending_full <= 1'b0;
            end else if (capture) begin
                pending      <= frame_in;
                pending_full <= 1'b1;
            end
            row_out    <= row_out_n;
            col_out    <= col_out_n;
            frame_done <= frame_done_n;
        end
    end

    assign frame_ready = ~pending_full;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: scenario tasks for led_matrix_scanner with
// PRESCALE=8, BLANK=2 (64-cycle frame), checked against a cycle-count
// reference model of the scan and the double buffer.
module tb_led_matrix_scanner;

    localparam int unsigned P  = 8;
    localparam int unsigned BL = 2;
    localparam int unsigned FR = 8 * P;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [7:0]  row_out;
    logic [7:0]  col_out;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model: t = cycles since reset release.
    int          t;
    logic [63:0] m_disp;
    logic [63:0] m_pend;
    bit          m_full;

    led_matrix_scanner #(.PRESCALE(P), .BLANK(BL)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .row_out     (row_out),
        .col_out     (col_out),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_row(int tt);
        int p;
        int r;
        p = tt % P;
        r = (tt / P) % 8;
        return (p < BL) ? 8'h00 : 8'(1 << r);
    endfunction

    function automatic logic [7:0] exp_col(int tt, logic [63:0] d);
        int p;
        int r;
        p = tt % P;
        r = (tt / P) % 8;
        return (p < BL) ? 8'h00 : d[8*r +: 8];
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        if ((t % FR) == FR - 1 && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end else if (frame_valid && !m_full) begin
            m_pend = frame_in;
            m_full = 1'b1;
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        frame_valid = 1'b0;
        frame_in    = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        t      = 0;
        m_disp = 64'd0;
        m_pend = 64'd0;
        m_full = 1'b0;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        frame_valid = 1'b0;
        frame_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (row_out !== 8'h00) begin errors++; $display("FAIL reset_row: got %h want 00", row_out); end
        checks++; if (col_out !== 8'h00) begin errors++; $display("FAIL reset_col: got %h want 00", col_out); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", frame_ready); end
        frame_in = 64'd0;
        reset    = 1'b1;
        t = 0; m_disp = 64'd0; m_pend = 64'd0; m_full = 1'b0;
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (row_out !== exp_row(t) || col_out !== 8'h00) begin
                errors++;
                $display("FAIL reset_scan t=%0d: row=%h col=%h want row=%h col=00", t, row_out, col_out, exp_row(t));
            end
            tick();
        end
    endtask

    task automatic test_diagonal();
        do_reset();
        tick();
        frame_in    = 64'h8040201008040201;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        frame_in    = 64'd0;
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL diag_ready_low: got %b want 0", frame_ready); end
        while (t < 2 * FR) begin
            if (t == FR - 1) begin
                checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL diag_done63: got %b want 1", frame_done); end
            end
            if (t == FR) begin
                checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL diag_ready64: got %b want 1", frame_ready); end
            end
            if (t >= FR) begin
                logic [7:0] want;
                want = ((t % P) < BL) ? 8'h00 : 8'(1 << ((t / P) % 8));
                checks++;
                if (row_out !== want || col_out !== want) begin
                    errors++;
                    $display("FAIL diag_scan t=%0d: row=%h col=%h want %h/%h", t, row_out, col_out, want, want);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int guard;
        do_reset();
        frame_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        frame_valid = 1'b1;
        tick();
        frame_in = 64'h0000_0000_0000_00FF;
        guard = 0;
        while (frame_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 200 || t != FR) begin
            errors++;
            $display("FAIL bp_ready_return: ready back at t=%0d want t=%0d", t, FR);
        end
        tick();
        frame_valid = 1'b0;
        frame_in    = 64'd0;
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL bp_capture_b: got %b want 0", frame_ready); end
        while (t < 3 * FR) begin
            logic [7:0] want;
            if (t < 2 * FR) want = ((t % P) < BL) ? 8'h00 : 8'hFF;
            else            want = ((t % P) < BL || (t / P) % 8 != 0) ? 8'h00 : 8'hFF;
            checks++;
            if (col_out !== want || row_out !== exp_row(t)) begin
                errors++;
                $display("FAIL bp_scan t=%0d: col=%h want %h row=%h want %h", t, col_out, want, row_out, exp_row(t));
            end
            tick();
        end
    endtask

    task automatic test_boundary_capture();
        logic [63:0] f;
        do_reset();
        f = {$urandom, $urandom} | 64'h1;
        while (t < FR - 1) tick();
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bc_done: got %b want 1", frame_done); end
        frame_in    = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        frame_in    = 64'd0;
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL bc_ready: got %b want 0", frame_ready); end
        while (t < 3 * FR) begin
            logic [7:0] want;
            want = (t < 2 * FR) ? 8'h00 : exp_col(t, f);
            checks++;
            if (col_out !== want) begin
                errors++;
                $display("FAIL bc_scan t=%0d: col=%h want %h", t, col_out, want);
            end
            if (t == 2 * FR) begin
                checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL bc_ready_after: got %b want 1", frame_ready); end
            end
            tick();
        end
    endtask

    task automatic test_periodicity();
        int done_cnt;
        int bad_done;
        int multi;
        int zeros;
        int bad_zero;
        do_reset();
        frame_in    = 64'hA5A5_5A5A_0F0F_F0F0;
        frame_valid = 1'b1;
        done_cnt = 0; bad_done = 0; multi = 0; zeros = 0; bad_zero = 0;
        for (int i = 0; i < 5 * FR; i++) begin
            if (frame_valid && frame_ready) frame_valid = 1'b1;
            if (frame_done === 1'b1) begin
                done_cnt++;
                if ((t % FR) != FR - 1) bad_done++;
            end
            if (!$onehot0(row_out)) multi++;
            if (row_out === 8'h00) zeros++;
            if ((t % FR) == FR - 1) begin
                if (zeros != 8 * BL) bad_zero++;
                zeros = 0;
            end
            tick();
        end
        frame_valid = 1'b0;
        checks++; if (done_cnt != 5) begin errors++; $display("FAIL per_done_count: got %0d want 5", done_cnt); end
        checks++; if (bad_done != 0) begin errors++; $display("FAIL per_done_pos: %0d misplaced pulses want 0", bad_done); end
        checks++; if (multi != 0) begin errors++; $display("FAIL per_onehot: %0d multi-hot cycles want 0", multi); end
        checks++; if (bad_zero != 0) begin errors++; $display("FAIL per_dark: %0d frames without 16 dark cycles want 0", bad_zero); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (!(frame_valid && !frame_ready)) begin
                frame_valid = ($urandom_range(0, 3) == 0);
                frame_in    = {$urandom, $urandom};
            end
            checks++;
            if (row_out !== exp_row(t) || col_out !== exp_col(t, m_disp) ||
                frame_done !== ((t % FR) == FR - 1) || frame_ready !== !m_full) begin
                errors++;
                $display("FAIL rand t=%0d: row=%h col=%h done=%b rdy=%b want %h %h %b %b", t, row_out, col_out,
                         frame_done, frame_ready, exp_row(t), exp_col(t, m_disp), (t % FR) == FR - 1, !m_full);
            end
            tick();
        end
        frame_valid = 1'b0;
    endtask

    task automatic test_reset_midscan();
        do_reset();
        frame_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        while (t < FR + 6) tick();
        frame_in    = 64'h1234_5678_9ABC_DEF0;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        while (t < FR + 8 * 4 + 5) tick();
        checks++; if (row_out !== 8'h10 || col_out !== 8'hFF) begin errors++; $display("FAIL mid_pre: row=%h col=%h want 10/ff", row_out, col_out); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL mid_pending: ready=%b want 0", frame_ready); end
        reset = 1'b0;
        #1;
        checks++; if (row_out !== 8'h00 || col_out !== 8'h00) begin errors++; $display("FAIL mid_async: row=%h col=%h want 00/00", row_out, col_out); end
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", frame_ready); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        t = 0; m_disp = 64'd0; m_pend = 64'd0; m_full = 1'b0;
        while (t < 2 * FR + 4) begin
            checks++;
            if (row_out !== exp_row(t) || col_out !== 8'h00 || frame_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_restart t=%0d: row=%h col=%h rdy=%b want %h 00 1", t, row_out, col_out, frame_ready, exp_row(t));
            end
            tick();
        end
    endtask

    initial begin
        reset       = 1'b0;
        frame_valid = 1'b0;
        frame_in    = 64'd0;
        t = 0; m_disp = 64'd0; m_pend = 64'd0; m_full = 1'b0;
        test_reset();
        test_diagonal();
        test_back_to_back();
        test_boundary_capture();
        test_periodicity();
        test_random();
        test_reset_midscan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
